// File: rtl/led_recver.sv
// LED receiver: takes beats from a NAP stream, buffers bytes from one source in a small FIFO,
// and shows each on the LEDs for a minimum hold time, with sequence checking and an inactivity timeout.
module led_recver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_CYCLES    = 10000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [3:0]                    expected_src,
    input  logic                          nap_valid,
    output logic                          nap_ready,
    input  logic [3:0]                    nap_addr,
    input  logic [DATA_WIDTH-1:0]         nap_data,
    output logic [7:0]                    led,
    output logic                          timeout,
    output logic [15:0]                   rx_count,
    output logic [7:0]                    drop_count,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_PRE  = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } drain_state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Registered state
    logic                 ready_en_r;
    logic [7:0]           mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    drain_state_t         state_r;
    logic [HW-1:0]        hold_r;
    logic [7:0]           led_r;
    logic                 clear_pending_r;
    logic [CW-1:0]        idle_r;
    logic                 timeout_r;
    logic                 ref_valid_r;
    logic [7:0]           ref_r;
    logic [15:0]          rx_r;
    logic [7:0]           drop_r;
    logic [7:0]           err_r;

    // Combinational decode
    logic                 nap_ready_s;
    logic                 accept_s;
    logic                 match_s;
    logic                 drop_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_empty_s;
    logic                 idle_empty_s;
    logic                 timeout_set_s;
    logic                 seq_err_s;
    logic [7:0]           byte_s;

    // Handshake, classification and event decode for this cycle
    always_comb begin
        byte_s        = nap_data[7:0];
        nap_ready_s   = ready_en_r && (level_r < DEPTH_L);
        accept_s      = nap_valid && nap_ready_s;
        match_s       = accept_s && (nap_addr == expected_src);
        drop_s        = accept_s && (nap_addr != expected_src);
        // ready already excludes a full FIFO, so every match can push
        push_s        = match_s;
        fifo_empty_s  = (level_r == {LW{1'b0}});
        idle_empty_s  = (state_r == ST_IDLE) && fifo_empty_s;
        pop_s         = (state_r == ST_IDLE) && !fifo_empty_s;
        timeout_set_s = !match_s && (idle_r == IDLE_PRE);
        // the reference is not trusted again until a byte has arrived after a timeout
        seq_err_s     = match_s && ref_valid_r && !timeout_r && (byte_s != rotl8(ref_r));
    end

    // Holds ready low for one cycle after reset release
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= byte_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Drain FSM: shows the FIFO head, then holds it before taking the next
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r         <= ST_IDLE;
            hold_r          <= {HW{1'b0}};
            led_r           <= 8'h00;
            clear_pending_r <= 1'b0;
        end else begin
            // a timeout seen while busy blanks the LEDs once the display goes quiet
            if (match_s) begin
                clear_pending_r <= 1'b0;
            end else if (timeout_set_s && !idle_empty_s) begin
                clear_pending_r <= 1'b1;
            end else if (idle_empty_s) begin
                clear_pending_r <= 1'b0;
            end else begin
                clear_pending_r <= clear_pending_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        led_r   <= mem_r[rd_ptr_r];
                        hold_r  <= HOLD_INIT;
                        state_r <= ST_HOLD;
                    end else if (timeout_set_s || (clear_pending_r && !match_s)) begin
                        led_r   <= 8'h00;
                    end else begin
                        led_r   <= led_r;
                    end
                end
                ST_HOLD: begin
                    if (hold_r == {HW{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        hold_r  <= hold_r - HW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hold_r  <= {HW{1'b0}};
                end
            endcase
        end
    end

    // Inactivity timer and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idle_r    <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (match_s) begin
                idle_r <= {CW{1'b0}};
            end else if (idle_r != IDLE_MAX) begin
                idle_r <= idle_r + CW'(1);
            end else begin
                idle_r <= idle_r;
            end

            if (match_s) begin
                timeout_r <= 1'b0;
            end else if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    // Sequence reference and statistics counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ref_valid_r <= 1'b0;
            ref_r       <= 8'h00;
            rx_r        <= 16'h0000;
            drop_r      <= 8'h00;
            err_r       <= 8'h00;
        end else begin
            if (match_s) begin
                ref_valid_r <= 1'b1;
                ref_r       <= byte_s;
                rx_r        <= rx_r + 16'd1;
            end
            if (drop_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
            if (seq_err_s && (err_r != 8'hFF)) begin
                err_r <= err_r + 8'd1;
            end
        end
    end

    assign nap_ready  = nap_ready_s;
    assign led        = led_r;
    assign timeout    = timeout_r;
    assign rx_count   = rx_r;
    assign drop_count = drop_r;
    assign err_count  = err_r;
    assign fifo_level = level_r;

endmodule

// File: doc/led_recver.md
LED_RECVER -- requirements
Module: led_recver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: receive buffer depth in entries; power of two, at least 2.
REQ-002 Parameter HOLD_CYCLES, default 10000000: minimum clk cycles each LED pattern is held before the next is shown; at least 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000000: clk cycles with no matching beat before timeout is asserted; at least 2.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 expected_src  input  4  only beats whose nap.addr equals this value are displayed.
REQ-007 nap (t_DATA_STREAM.rx) nap.valid  input  1  transmitter offers a beat.
REQ-008 nap.ready  output  1  this block can accept a beat.
REQ-009 nap.addr  input  4  source address of the beat.
REQ-010 nap.data  input  interface width  payload; only bits [7:0] are used.
REQ-011 led  output  8  registered LED pattern.
REQ-012 timeout  output  1  sticky flag: no matching traffic within TIMEOUT_CYCLES.
REQ-013 rx_count  output  16  matching beats accepted; wraps modulo 2^16.
REQ-014 drop_count  output  8  non-matching beats accepted and discarded; saturates at 255.
REQ-015 err_count  output  8  rotation-sequence violations; saturates at 255.
REQ-016 fifo_level  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-017 A beat SHALL be accepted on a rising edge where nap.valid and nap.ready are both high; no other edge accepts a beat.
REQ-018 nap.ready SHALL be low during reset and in the first cycle after release; thereafter it SHALL equal (fifo_level < FIFO_DEPTH), combinational from registered state.
REQ-019 An accepted beat with nap.addr == expected_src SHALL push nap.data[7:0] into the FIFO and increment rx_count.
REQ-020 An accepted beat with nap.addr != expected_src SHALL not be pushed and SHALL increment drop_count.
REQ-021 When a push and a pop occur on the same edge, fifo_level SHALL be unchanged; a full FIFO SHALL never be pushed and an empty FIFO SHALL never be popped.
REQ-022 Sequence check: each matching byte after the first SHALL equal the previous matching byte rotated left by one bit ({prev[6:0],prev[7]}); otherwise err_count increments.
REQ-023 The first matching byte after reset, and the first after timeout was set, SHALL only establish the reference and SHALL not be checked.
REQ-024 Drain FSM state IDLE: if the FIFO is non-empty, on the next edge led <= FIFO head, pop, hold_cnt <= HOLD_CYCLES-1, and go to HOLD.
REQ-025 Drain FSM state HOLD: if hold_cnt == 0 go to IDLE, else decrement hold_cnt; LED updates are therefore spaced at least HOLD_CYCLES+1 cycles apart.
REQ-026 The idle counter SHALL reset to 0 on every matching accept and otherwise increment, saturating at TIMEOUT_CYCLES-1.
REQ-027 On the edge where the idle counter reaches TIMEOUT_CYCLES-1, timeout <= 1 and led <= 0; led is cleared only when the FIFO is empty and the FSM is in IDLE, otherwise at the next IDLE-with-empty-FIFO edge.
REQ-028 timeout SHALL clear on the edge of the next matching accept.
REQ-029 A matching accept on the same edge the idle counter would reach TIMEOUT_CYCLES-1 SHALL take precedence: timeout stays 0.
REQ-030 Non-matching beats SHALL neither reset the idle counter nor clear timeout.

Reset
REQ-031 While resetn is low: led=0, timeout=0, all counters=0, fifo_level=0, FSM=IDLE, hold_cnt=0, sequence reference invalid, nap.ready=0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any HOLD in progress on the same edge.

Verification (bench parameters: FIFO_DEPTH=4, HOLD_CYCLES=4, TIMEOUT_CYCLES=50, expected_src=3)
REQ-033 Bytes 0x01, 0x02, 0x04 from addr 3, back-to-back -> led shows 01/02/04, each update 5 cycles apart; rx_count=3, err_count=0.
REQ-034 Hold valid high with 8 matching beats -> ready drops when fifo_level=4, no beat lost or duplicated, LED sequence in order.
REQ-035 Beats 0x10 from addr 5, then 0x20 from addr 3 -> drop_count=1, rx_count=1, led=0x20, no error.
REQ-036 Matching 0x01 then 0x08 -> err_count=1; 255 further violations -> err_count holds at 255.
REQ-037 No traffic for 50 cycles -> timeout=1, led=0x00; next matching 0x80 -> timeout=0, led=0x80, no error counted.
REQ-038 resetn low for 1 cycle while fifo_level=3 and in HOLD -> all outputs at reset values next cycle; ready=1 one cycle after release.
